// File: rtl/ifid_pipe_reg.sv
// Multi-lane IF/ID pipeline register with valid/ready handshake, flush and optional skid entry.
// Outputs always reflect the main entry; an invalid entry presents an all-NOP, zero-PC bundle.
module ifid_pipe_reg #(
    parameter int unsigned LANES = 2,
    parameter int unsigned XLEN  = 32,
    parameter logic [31:0] NOP   = 32'h00000013,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [XLEN*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]     in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [XLEN*LANES-1:0]   out_pc,
    output logic [32*LANES-1:0]     out_inst,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic                  m_valid;
    logic [LANES-1:0]      m_lane_valid;
    logic [XLEN*LANES-1:0] m_pc;
    logic [32*LANES-1:0]   m_inst;

    logic                  s_valid;
    logic [LANES-1:0]      s_lane_valid;
    logic [XLEN*LANES-1:0] s_pc;
    logic [32*LANES-1:0]   s_inst;

    logic                  advance;
    logic                  accept;
    logic [XLEN*LANES-1:0] cap_pc;
    logic [32*LANES-1:0]   cap_inst;

    assign advance = !m_valid || out_ready;

    // With a skid entry, in_ready depends only on registered state, breaking the out_ready path.
    assign in_ready = (SKID != 0) ? !s_valid : advance;
    assign accept   = in_valid && in_ready && !flush && (|in_lane_valid);

    always_comb begin
        cap_pc   = '0;
        cap_inst = {LANES{NOP}};
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_lane_valid[i]) begin
                cap_pc[i*XLEN +: XLEN] = in_pc[i*XLEN +: XLEN];
                cap_inst[i*32 +: 32]   = in_inst[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_valid      <= 1'b0;
            m_lane_valid <= '0;
            m_pc         <= '0;
            m_inst       <= {LANES{NOP}};
            s_valid      <= 1'b0;
            s_lane_valid <= '0;
            s_pc         <= '0;
            s_inst       <= {LANES{NOP}};
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (advance) begin
            if (s_valid) begin
                m_valid      <= 1'b1;
                m_lane_valid <= s_lane_valid;
                m_pc         <= s_pc;
                m_inst       <= s_inst;
                s_valid      <= 1'b0;
            end else if (accept) begin
                m_valid      <= 1'b1;
                m_lane_valid <= in_lane_valid;
                m_pc         <= cap_pc;
                m_inst       <= cap_inst;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid      <= 1'b1;
            s_lane_valid <= in_lane_valid;
            s_pc         <= cap_pc;
            s_inst       <= cap_inst;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        out_valid      = m_valid;
        out_lane_valid = m_valid ? m_lane_valid : '0;
        out_pc         = m_valid ? m_pc : '0;
        out_inst       = m_valid ? m_inst : {LANES{NOP}};
    end

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: a SKID=1 build and a SKID=0/CNT_W=2 build checked each cycle
// against a bounded-FIFO reference model, plus directed scenarios.
module tb_ifid_pipe_reg;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [63:0] NOP2 = {NOP, NOP};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clrn = 1'b1;

    logic        flush_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a;
    logic [1:0]  in_lane_valid_a, out_lane_valid_a;
    logic [63:0] in_pc_a, in_inst_a, out_pc_a, out_inst_a;
    logic [15:0] stall_cnt_a;

    logic        flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b;
    logic [1:0]  in_lane_valid_b, out_lane_valid_b;
    logic [63:0] in_pc_b, in_inst_b, out_pc_b, out_inst_b;
    logic [1:0]  stall_cnt_b;

    ifid_pipe_reg #(.LANES(2), .XLEN(32), .NOP(NOP), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .clrn(clrn), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_lane_valid(in_lane_valid_a), .in_pc(in_pc_a), .in_inst(in_inst_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_lane_valid(out_lane_valid_a),
        .out_pc(out_pc_a), .out_inst(out_inst_a), .stall_cnt(stall_cnt_a)
    );

    ifid_pipe_reg #(.LANES(2), .XLEN(32), .NOP(NOP), .SKID(0), .CNT_W(2)) dut_b (
        .clk(clk), .clrn(clrn), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_lane_valid(in_lane_valid_b), .in_pc(in_pc_b), .in_inst(in_inst_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_lane_valid(out_lane_valid_b),
        .out_pc(out_pc_b), .out_inst(out_inst_b), .stall_cnt(stall_cnt_b)
    );

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pc;
        logic [63:0] inst;
    } bundle_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit b_rand  = 1'b1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [1:0] lv, input logic [63:0] pc, input logic [63:0] inst);
        bundle_t b;
        b.lv   = lv;
        b.pc   = '0;
        b.inst = NOP2;
        for (int i = 0; i < 2; i++) begin
            if (lv[i]) begin
                b.pc[i*32 +: 32]   = pc[i*32 +: 32];
                b.inst[i*32 +: 32] = inst[i*32 +: 32];
            end
        end
        return b;
    endfunction

    // Reference: each build is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0); head is on the outputs.
    bundle_t qa[$];
    bundle_t qb[$];
    int      cnt_a, cnt_b;
    int      sa, sb;
    bit      ra, rb;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            sa = qa.size();
            ra = (sa < 2);
            if (sa != 0 && !out_ready_a && !flush_a && cnt_a < 65535) cnt_a++;
            if (flush_a) qa.delete();
            else begin
                if (sa != 0 && out_ready_a) void'(qa.pop_front());
                if (in_valid_a && ra && in_lane_valid_a != 2'b00)
                    qa.push_back(mk(in_lane_valid_a, in_pc_a, in_inst_a));
            end

            sb = qb.size();
            rb = (sb == 0) || out_ready_b;
            if (sb != 0 && !out_ready_b && !flush_b && cnt_b < 3) cnt_b++;
            if (flush_b) qb.delete();
            else begin
                if (sb != 0 && out_ready_b) void'(qb.pop_front());
                if (in_valid_b && rb && in_lane_valid_b != 2'b00)
                    qb.push_back(mk(in_lane_valid_b, in_pc_b, in_inst_b));
            end
        end
    end

    task automatic check_outputs();
        bundle_t ea, eb;
        ea = mk(2'b00, '0, '0);
        eb = mk(2'b00, '0, '0);
        if (qa.size() != 0) ea = qa[0];
        if (qb.size() != 0) eb = qb[0];
        check("a.out_valid", out_valid_a, qa.size() != 0);
        check("a.lane_valid", out_lane_valid_a, ea.lv);
        check("a.out_pc", out_pc_a, ea.pc);
        check("a.out_inst", out_inst_a, ea.inst);
        check("a.in_ready", in_ready_a, qa.size() < 2);
        check("a.stall_cnt", stall_cnt_a, cnt_a);
        check("b.out_valid", out_valid_b, qb.size() != 0);
        check("b.lane_valid", out_lane_valid_b, eb.lv);
        check("b.out_pc", out_pc_b, eb.pc);
        check("b.out_inst", out_inst_b, eb.inst);
        check("b.in_ready", in_ready_b, (qb.size() == 0) || out_ready_b);
        check("b.stall_cnt", stall_cnt_b, cnt_b);
    endtask

    task automatic set_a(input logic fl, input logic v, input logic [1:0] lv,
                         input logic [63:0] pc, input logic [63:0] inst, input logic rdy);
        flush_a = fl; in_valid_a = v; in_lane_valid_a = lv;
        in_pc_a = pc; in_inst_a = inst; out_ready_a = rdy;
    endtask

    task automatic set_b(input logic fl, input logic v, input logic [1:0] lv,
                         input logic [63:0] pc, input logic [63:0] inst, input logic rdy);
        flush_b = fl; in_valid_b = v; in_lane_valid_b = lv;
        in_pc_b = pc; in_inst_b = inst; out_ready_b = rdy;
    endtask

    task automatic rnd_a();
        set_a($urandom_range(15) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(3) != 0);
    endtask

    task automatic rnd_b();
        set_b($urandom_range(15) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(3) != 0);
    endtask

    // Inputs are already driven; settle, compare, then step across one rising edge.
    task automatic tick();
        if (b_rand) rnd_b();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pcs(input int k);
        logic [31:0] base;
        base = 32'(k * 8);
        return {base + 32'd4, base};
    endfunction

    initial begin
        set_a(0, 0, 2'b00, '0, '0, 1'b1);
        set_b(0, 0, 2'b00, '0, '0, 1'b1);
        #1 clrn = 1'b0;
        #1 check_outputs();
        check("reset.a_inst", out_inst_a, NOP2);
        check("reset.a_ready", in_ready_a, 1'b1);
        #6 clrn = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, then three cycles of back-pressure on the skid build
        for (int k = 0; k < 4; k++) begin
            set_a(0, 1, 2'b11, pcs(k), {$urandom, $urandom}, 1'b1);
            tick();
        end
        check("stream.stall", stall_cnt_a, 16'd0);
        for (int k = 4; k < 7; k++) begin
            set_a(0, 1, 2'b11, pcs(k), {$urandom, $urandom}, 1'b0);
            tick();
        end
        check("bp.stall", stall_cnt_a, 16'd3);
        check("bp.in_ready", in_ready_a, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_a(0, 0, 2'b00, '0, '0, 1'b1);
            tick();
        end

        // Flush with both entries full and an incoming bundle
        set_a(0, 1, 2'b11, pcs(20), {$urandom, $urandom}, 1'b0);
        tick();
        set_a(0, 1, 2'b11, pcs(21), {$urandom, $urandom}, 1'b0);
        tick();
        set_a(1, 1, 2'b11, pcs(22), {$urandom, $urandom}, 1'b0);
        tick();
        set_a(0, 0, 2'b00, '0, '0, 1'b1);
        #1;
        check("flush.out_valid", out_valid_a, 1'b0);
        check("flush.in_ready", in_ready_a, 1'b1);
        check("flush.out_inst", out_inst_a, NOP2);
        tick();

        // Partial bundles
        set_a(0, 1, 2'b01, 64'h00000104_00000100, 64'hDEADBEEF_00500093, 1'b1);
        tick();
        set_a(0, 0, 2'b00, '0, '0, 1'b1);
        #1;
        check("partial.inst1", out_inst_a[63:32], NOP);
        check("partial.inst0", out_inst_a[31:0], 32'h00500093);
        check("partial.lv", out_lane_valid_a, 2'b01);
        set_a(0, 1, 2'b00, pcs(30), {$urandom, $urandom}, 1'b1);
        tick();
        set_a(0, 0, 2'b00, '0, '0, 1'b1);
        #1;
        check("empty.out_valid", out_valid_a, 1'b0);
        tick();

        // Asynchronous reset in the middle of a stall
        for (int k = 0; k < 3; k++) begin
            set_a(0, 1, 2'b11, pcs(40 + k), {$urandom, $urandom}, 1'b0);
            tick();
        end
        #1 clrn = 1'b0;
        #1;
        check("areset.out_valid", out_valid_a, 1'b0);
        check("areset.stall", stall_cnt_a, 16'd0);
        check("areset.out_pc", out_pc_a, 64'd0);
        check("areset.in_ready", in_ready_a, 1'b1);
        check_outputs();
        #1 clrn = 1'b1;
        set_a(0, 0, 2'b00, '0, '0, 1'b1);
        tick();

        // SKID=0 build: combinational in_ready and counter saturation
        b_rand = 1'b0;
        set_b(0, 1, 2'b11, pcs(50), 64'h00000013_00100093, 1'b1);
        tick();
        set_b(0, 0, 2'b00, '0, '0, 1'b0);
        #1 check("b.comb_ready_lo", in_ready_b, 1'b0);
        out_ready_b = 1'b1;
        #1 check("b.comb_ready_hi", in_ready_b, 1'b1);
        out_ready_b = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("b.stall_sat", stall_cnt_b, 2'd3);
        b_rand = 1'b1;

        // Random traffic on both builds
        for (int k = 0; k < 400; k++) begin
            rnd_a();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_reg.md
# ifid_pipe_reg

Parametrised, multi-lane IF/ID pipeline register for the superscalar front end. It carries a fetch bundle of `LANES` instructions with per-lane PC and valid bits from fetch to decode. It uses a valid/ready handshake, a flush input for taken branches and jumps, and an optional skid entry so that `in_ready` is a registered signal. It replaces the single-lane stall/flush register and adds a saturating stall counter for performance monitoring.

## Interface

Parameters:

- `LANES`, 2, number of instruction slots per fetch bundle (≥1)
- `XLEN`, 32, PC width
- `NOP`, 32'h00000013, encoding inserted into empty or invalid slots (`addi x0,x0,0`)
- `SKID`, 1, 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `CNT_W`, 16, stall counter width

Ports:

- `clk` in 1: rising-edge clock; the block uses one clock only
- `clrn` in 1: asynchronous, active-low reset
- `flush` in 1: discard all held and incoming bundles (branch or jump redirect)
- `in_valid` in 1: fetch presents a bundle
- `in_ready` out 1: register can accept a bundle
- `in_lane_valid` in `LANES`: per-slot valid
- `in_pc` in `XLEN*LANES`: per-slot PC, with slot i at bits `[i*XLEN +: XLEN]`
- `in_inst` in `32*LANES`: per-slot instruction
- `out_valid` out 1: bundle presented to decode
- `out_ready` in 1: decode accepts the bundle (0 = load-use or structural stall)
- `out_lane_valid` out `LANES`: per-slot valid
- `out_pc` out `XLEN*LANES`: per-slot PC
- `out_inst` out `32*LANES`: per-slot instruction
- `stall_cnt` out `CNT_W`: saturating count of back-pressure cycles

## Operation

Storage:
- Main entry M; skid entry S exists only when `SKID=1`.
- Each entry holds `valid`, `lane_valid`, `pc` and `inst`.

Input acceptance:
- An input transfer (accept) occurs when `in_valid && in_ready && !flush && |in_lane_valid`.
- A bundle with all `in_lane_valid=0` is consumed without occupying an entry. It is not a transfer.
- On capture, every slot with `lane_valid=0` stores `inst=NOP` and `pc=0`.

Output and advance:
- Output drain: `out_valid && out_ready`.
- M may load ("advance") when `!M.valid || out_ready`.
- Outputs always reflect M.
- When M is invalid: `out_lane_valid=0`, `out_pc=0`, and all `out_inst` slots are `NOP`.

Next-state rules, in priority order:
1. `flush` clears `M.valid` and `S.valid`; any same-cycle input is dropped. Flush overrides every other event.
2. If M may advance and `S.valid`: M ← S and S is cleared.
3. Else if M may advance and an accept occurs: M ← input.
4. Else if M may advance: `M.valid` ← 0.
5. If M cannot advance (valid and stalled) and an accept occurs: S ← input. Only possible with `SKID=1`.

`in_ready`:
- `SKID=1`: `in_ready = !S.valid`, a registered-only term with no path from `out_ready`.
- `SKID=0`: `in_ready = !M.valid || out_ready`, combinational.

Stall counter:
- `stall_cnt` increments when `out_valid && !out_ready && !flush`.
- It saturates at all-ones and never wraps.
- Only `clrn` clears it.

Ordering: bundles leave in acceptance order. None are lost or duplicated except through flush.

## Timing

- Reset (asynchronous, immediate on `clrn=0`):
  - M and S invalid
  - `out_valid=0`, `out_lane_valid=0`, `out_pc=0`, `out_inst` all `NOP`
  - `in_ready=1`, `stall_cnt=0`
- Reset asserted mid-stall discards held bundles. The first accept after `clrn` rises is at the first rising edge with `clrn=1`.
- Latency: a bundle accepted at edge t appears on the outputs after edge t (one cycle).
- Throughput: one bundle per cycle while `out_ready=1`.
- `SKID=1` back-pressure:
  - In the first cycle with `out_ready=0`, one more bundle can be accepted into S.
  - `in_ready` falls after that edge.
  - After `out_ready` returns to 1, S moves to M on the next edge and `in_ready` rises after that same edge.
- Flush:
  - Takes effect at the next edge.
  - `out_valid=0` in the following cycle.
  - `in_ready=1` in the following cycle.
  - The bundle present in the flush cycle is never delivered.
- Simultaneous drain and accept with S empty: M is replaced by the input (pass-through, no bubble).
- Simultaneous `flush` and `out_ready`: the current M counts as drained by decode. Its removal is still required.

## Test plan

- **Streaming:** reset, then `LANES=2`, `out_ready=1`, 4 bundles with PCs 0x0/0x4 … 0x18/0x1C back-to-back → each appears one cycle later, in order; `stall_cnt=0`.
- **Back-pressure with skid:** `out_ready=0` for 3 cycles during a stream → exactly one extra bundle is accepted, `in_ready=0` for cycles 2–3, `stall_cnt=3`. After release, the two held bundles are delivered on consecutive cycles with no loss.
- **Flush:** M and S both full, pulse `flush` with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, `out_inst` = {`NOP`,`NOP`}; the flushed PCs never appear.
- **Partial bundle:** `in_lane_valid=2'b01`, inst1=0xDEADBEEF → `out_inst[63:32]=0x00000013`, `out_lane_valid=2'b01`. With `in_lane_valid=2'b00` → no output bundle.
- **Asynchronous reset mid-stall:** drop `clrn` between edges → outputs return to reset values immediately; `stall_cnt=0`.
- **`SKID=0`, `CNT_W=2` build:**
  - `in_ready` follows `out_ready` combinationally while M is valid.
  - 5 stall cycles → `stall_cnt` saturates at 3.
